// File: rtl/atm_pkg.sv
// atm_pkg: shared operation and state encodings for the ATM session controller
package atm_pkg;
  typedef enum logic [1:0] {OP_WD = 2'b00, OP_DEP = 2'b01, OP_INQ = 2'b10, OP_ILL = 2'b11} op_e;
  typedef enum logic [2:0] {IDLE, PIN, MENU, EXEC, RESULT, ANOTHER, EJECT, RETAIN} state_e;
endpackage

// File: rtl/atm_txn_ctrl_if.sv
// atm_txn_ctrl_if: keypad/card front-end and account-store signals of one ATM session
interface atm_txn_ctrl_if #(parameter int bw = 20);
  logic card_in, psw_valid, psw_ok, language, op_valid, svc_valid, another_service;
  logic [1:0] operation;
  logic [bw-1:0] current_balance, value, balance;
  logic lang_sel, busy, op_done, error, card_out, card_retained;
  modport master(
    output card_in, current_balance, psw_valid, psw_ok, language, op_valid, operation, value,
           svc_valid, another_service,
    input balance, lang_sel, busy, op_done, error, card_out, card_retained
  );
  modport slave(
    input card_in, current_balance, psw_valid, psw_ok, language, op_valid, operation, value,
          svc_valid, another_service,
    output balance, lang_sel, busy, op_done, error, card_out, card_retained
  );
endinterface

// File: rtl/atm_idle_timer.sv
// atm_idle_timer: reloadable inactivity down-counter that parks at zero and flags expiry
module atm_idle_timer #(
  parameter int timeout_cycles = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);
  localparam int tw = $clog2(timeout_cycles + 1);
  logic [tw-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else if (load) cnt <= tw'(timeout_cycles);
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expired = cnt == '0;
endmodule

// File: rtl/atm_txn_ctrl.sv
// atm_txn_ctrl: one card session with PIN retries, idle timeout and limited withdrawals
module atm_txn_ctrl
  import atm_pkg::*;
#(
  parameter int balance_width  = 20,
  parameter int max_tries      = 3,
  parameter int timeout_cycles = 16,
  parameter int wd_limit       = 5000
) (
  input logic clk,
  input logic rst,
  atm_txn_ctrl_if.slave bus
);
  localparam int bw = balance_width;
  localparam int tw = $clog2(max_tries + 1);
  state_e state;
  op_e op;
  logic [bw-1:0] val, bal, withdrawn;
  logic [bw:0] wd_sum, dep_sum;
  logic [tw-1:0] tries;
  logic err, done, cout, cret, lang, ok, expired, wait_st, strobe, tmr_load;
  always_comb begin
    wd_sum   = {1'b0, withdrawn} + {1'b0, val};
    dep_sum  = {1'b0, bal} + {1'b0, val};
    ok       = op == OP_WD  ? (val <= bal && wd_sum <= (bw+1)'(wd_limit)) :
               op == OP_DEP ? !dep_sum[bw] : op == OP_INQ;
    wait_st  = state == PIN || state == MENU || state == ANOTHER;
    strobe   = (state == PIN && bus.psw_valid) || (state == MENU && bus.op_valid) ||
               (state == ANOTHER && bus.svc_valid);
    // RESULT always leads to ANOTHER, so loading there covers entry to ANOTHER
    tmr_load = strobe || (state == IDLE && bus.card_in) || state == RESULT;
  end
  atm_idle_timer #(.timeout_cycles(timeout_cycles)) u_tmr (
    .clk(clk), .rst(rst), .load(tmr_load), .dec(wait_st), .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      op <= OP_WD;
      val <= '0;
      bal <= '0;
      withdrawn <= '0;
      tries <= '0;
      err <= 1'b0;
      done <= 1'b0;
      cout <= 1'b0;
      cret <= 1'b0;
      lang <= 1'b0;
    end else begin
      done <= 1'b0;
      cout <= 1'b0;
      cret <= 1'b0;
      case (state)
        IDLE: if (bus.card_in) begin
          state <= PIN;
          bal <= bus.current_balance;
          lang <= bus.language;
          err <= 1'b0;
          tries <= '0;
          withdrawn <= '0;
        end
        PIN: if (bus.psw_valid) begin
          if (bus.psw_ok) state <= MENU;
          else begin
            tries <= tries + 1'b1;
            if (tries + 1'b1 == tw'(max_tries)) state <= RETAIN;
          end
        end else if (expired) begin
          state <= EJECT;
          err <= 1'b1;
        end
        MENU: if (bus.op_valid) begin
          state <= EXEC;
          op <= op_e'(bus.operation);
          val <= bus.value;
        end else if (expired) begin
          state <= EJECT;
          err <= 1'b1;
        end
        EXEC: begin
          err <= !ok;
          if (ok && op == OP_WD) begin
            bal <= bal - val;
            withdrawn <= wd_sum[bw-1:0];
          end
          if (ok && op == OP_DEP) bal <= dep_sum[bw-1:0];
          state <= RESULT;
        end
        RESULT: begin
          done <= 1'b1;
          state <= ANOTHER;
        end
        ANOTHER: if (bus.svc_valid) begin
          state <= bus.another_service ? MENU : EJECT;
          if (bus.another_service) err <= 1'b0;
        end else if (expired) begin
          state <= EJECT;
          err <= 1'b1;
        end
        EJECT: begin
          cout <= 1'b1;
          state <= IDLE;
        end
        RETAIN: begin
          cret <= 1'b1;
          err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.balance = bal;
  assign bus.lang_sel = lang;
  assign bus.busy = state != IDLE;
  assign bus.op_done = done;
  assign bus.error = err;
  assign bus.card_out = cout;
  assign bus.card_retained = cret;
endmodule

// File: tb/tb_atm_txn_ctrl.sv
// tb_atm_txn_ctrl: table-driven single-operation sessions plus multi-cycle corner sequences
module tb_atm_txn_ctrl;
  import atm_pkg::*;
  typedef struct {
    logic [19:0] bal;
    op_e op;
    logic [19:0] val;
    logic [19:0] exp_bal;
    logic exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t vt[10];
  always #5 clk = ~clk;
  atm_txn_ctrl_if #(.bw(20)) bus();
  atm_txn_ctrl #(.balance_width(20), .max_tries(3), .timeout_cycles(16), .wd_limit(5000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic insert(input logic [19:0] b, input logic lang);
    bus.current_balance = b;
    bus.language = lang;
    bus.card_in = 1'b1;
    tick;
    bus.card_in = 1'b0;
  endtask
  task automatic pin(input logic good);
    bus.psw_valid = 1'b1;
    bus.psw_ok = good;
    tick;
    bus.psw_valid = 1'b0;
  endtask
  task automatic svc(input logic more);
    bus.svc_valid = 1'b1;
    bus.another_service = more;
    tick;
    bus.svc_valid = 1'b0;
  endtask
  task automatic do_op(input string name, input op_e o, input logic [19:0] v,
                       input logic [19:0] exp_bal, input logic exp_err);
    int n = 0;
    bus.op_valid = 1'b1;
    bus.operation = o;
    bus.value = v;
    tick;
    bus.op_valid = 1'b0;
    while (!bus.op_done && n < 6) begin
      tick;
      n++;
    end
    check({name, "_latency"}, n, 2);
    check({name, "_error"}, bus.error, exp_err);
    check({name, "_balance"}, bus.balance, exp_bal);
    tick;
    check({name, "_done_pulse"}, bus.op_done, 0);
  endtask
  task automatic finish_session(input string name, input logic [19:0] exp_bal);
    svc(1'b0);
    check({name, "_cout_early"}, bus.card_out, 0);
    tick;
    check({name, "_card_out"}, bus.card_out, 1);
    check({name, "_final_bal"}, bus.balance, exp_bal);
    check({name, "_idle"}, bus.busy, 0);
    tick;
    check({name, "_cout_pulse"}, bus.card_out, 0);
  endtask
  initial begin
    int n;
    vt[0] = '{1000, OP_WD, 300, 700, 1'b0};
    vt[1] = '{1000, OP_WD, 1200, 1000, 1'b1};
    vt[2] = '{1048573, OP_DEP, 5, 1048573, 1'b1};
    vt[3] = '{1048573, OP_DEP, 2, 1048575, 1'b0};
    vt[4] = '{9000, OP_WD, 5000, 4000, 1'b0};
    vt[5] = '{9000, OP_WD, 5001, 9000, 1'b1};
    vt[6] = '{700, OP_INQ, 0, 700, 1'b0};
    vt[7] = '{700, OP_ILL, 10, 700, 1'b1};
    vt[8] = '{300, OP_WD, 300, 0, 1'b0};
    vt[9] = '{50, OP_DEP, 50, 100, 1'b0};
    {bus.card_in, bus.psw_valid, bus.psw_ok, bus.language, bus.op_valid, bus.svc_valid} = '0;
    bus.another_service = 1'b0;
    bus.operation = 2'b00;
    bus.value = '0;
    bus.current_balance = '0;
    tick;
    tick;
    check("reset_outputs", {bus.balance, bus.busy, bus.error, bus.lang_sel, bus.op_done,
                            bus.card_out, bus.card_retained}, 0);
    rst = 1'b1;
    tick;
    for (int i = 0; i < 10; i++) begin
      insert(vt[i].bal, i[0]);
      check($sformatf("vec%0d_lang", i), bus.lang_sel, i[0]);
      pin(1'b1);
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].val, vt[i].exp_bal, vt[i].exp_err);
      finish_session($sformatf("vec%0d", i), vt[i].exp_bal);
    end
    insert(1000, 1'b0);
    pin(1'b1);
    do_op("over", OP_WD, 1200, 1000, 1'b1);
    svc(1'b1);
    check("continue_clears_error", bus.error, 0);
    do_op("wd100", OP_WD, 100, 900, 1'b0);
    bus.current_balance = 5;
    bus.card_in = 1'b1;
    tick;
    bus.card_in = 1'b0;
    check("card_in_ignored", {bus.busy, bus.balance}, {1'b1, 20'd900});
    finish_session("cont", 900);
    insert(9000, 1'b0);
    pin(1'b1);
    do_op("lim1", OP_WD, 3000, 6000, 1'b0);
    svc(1'b1);
    do_op("lim2", OP_WD, 2500, 6000, 1'b1);
    finish_session("lim", 6000);
    insert(1048573, 1'b0);
    pin(1'b1);
    do_op("dep5", OP_DEP, 5, 1048573, 1'b1);
    svc(1'b1);
    do_op("dep2", OP_DEP, 2, 1048575, 1'b0);
    finish_session("dep", 1048575);
    insert(500, 1'b0);
    pin(1'b0);
    pin(1'b0);
    pin(1'b1);
    check("retry_busy", bus.busy, 1);
    do_op("retry_inq", OP_INQ, 0, 500, 1'b0);
    finish_session("retry", 500);
    insert(500, 1'b0);
    pin(1'b0);
    pin(1'b0);
    check("two_bad_stay", {bus.busy, bus.card_retained}, 2'b10);
    pin(1'b0);
    check("retain_not_yet", bus.card_retained, 0);
    tick;
    check("retain_pulse", {bus.card_retained, bus.error, bus.busy}, 3'b110);
    tick;
    check("retain_pulse_end", bus.card_retained, 0);
    insert(800, 1'b0);
    pin(1'b1);
    n = 0;
    while (!bus.card_out && n < 40) begin
      tick;
      n++;
    end
    check("timeout_window", n >= 17 && n <= 19, 1);
    check("timeout_error", bus.error, 1);
    check("timeout_balance", bus.balance, 800);
    insert(1000, 1'b1);
    pin(1'b1);
    bus.op_valid = 1'b1;
    bus.operation = OP_WD;
    bus.value = 300;
    tick;
    bus.op_valid = 1'b0;
    rst = 1'b0;
    tick;
    check("reset_in_exec", {bus.balance, bus.busy, bus.error, bus.lang_sel, bus.op_done,
                            bus.card_out, bus.card_retained}, 0);
    rst = 1'b1;
    tick;
    check("reset_no_eject", {bus.card_out, bus.busy}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
